// File: rtl/expr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : expr_pkg
// Purpose  : Shared constants for the expression evaluator. Holds the FSM
//            state encodings, the ASCII codes the evaluator recognises, and
//            the decoded-character struct produced by ascii_class.
// Revision : 1.0  initial release
// ============================================================================
package expr_pkg;

  // FSM state encodings (two bits, legacy-compatible constants)
  localparam logic [1:0] EXP_D  = 2'd0;  // expecting a digit (start state)
  localparam logic [1:0] EXP_OP = 2'd1;  // last char was a digit
  localparam logic [1:0] ERR    = 2'd2;  // syntax error seen, sticky until '='

  // ASCII codes
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

  // Decoded character classes
  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
    logic       is_plus;
    logic       is_star;
    logic       is_eq;
  } ch_class_t;

endpackage : expr_pkg
`default_nettype wire

// File: rtl/expr_eval_if.sv
`default_nettype none
// ============================================================================
// Module   : expr_eval_if
// Purpose  : Character-stream and result bus of the expression evaluator.
// Ports    : in[7:0], in_valid   - character stream (master -> slave)
//            result[W-1:0], done,
//            err, ovf            - completion report  (slave -> master)
// Revision : 1.0  initial release
// ============================================================================
interface expr_eval_if #(
  parameter int W = 16
) ();

  logic [7:0]   in;
  logic         in_valid;
  logic [W-1:0] result;
  logic         done;
  logic         err;
  logic         ovf;

  modport master (
    output in, in_valid,
    input  result, done, err, ovf
  );

  modport slave (
    input  in, in_valid,
    output result, done, err, ovf
  );

endinterface : expr_eval_if
`default_nettype wire

// File: rtl/expr_eval_ascii_class.sv
`default_nettype none
// ============================================================================
// Module   : ascii_class
// Purpose  : Combinational decode of one ASCII character into the classes
//            the evaluator cares about.
// Ports    : ch[7:0]  in   character to classify
//            cls      out  is_digit, digit value, is_plus, is_star, is_eq
// Revision : 1.0  initial release
// ============================================================================
module ascii_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output ch_class_t  cls
);

  logic [7:0] w_off;

  always_comb begin
    w_off        = ch - CH_0;
    cls.is_digit = (ch >= CH_0) && (ch <= CH_9);
    // only meaningful when is_digit is set; zero otherwise to keep it quiet
    cls.digit    = cls.is_digit ? w_off[3:0] : 4'd0;
    cls.is_plus  = (ch == CH_PLUS);
    cls.is_star  = (ch == CH_STAR);
    cls.is_eq    = (ch == CH_EQ);
  end

endmodule : ascii_class
`default_nettype wire

// File: rtl/expr_eval.sv
`default_nettype none
// ============================================================================
// Module   : expr_eval
// Purpose  : Evaluates "d op d op ... d =" expressions (single digits, '+'
//            and '*', '*' binding tighter) modulo 2^W, checking the grammar
//            and flagging overflow of any intermediate value.
// Ports    : clk    in   rising-edge clock
//            clr_n  in   asynchronous active-low reset
//            bus    slave modport of expr_eval_if:
//                     in/in_valid consumed each edge in_valid is high;
//                     result/done/err/ovf registered, valid the cycle
//                     after the terminating '='.
// Revision : 1.0  initial release
// ============================================================================
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        clr_n,
  expr_eval_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]   r_state;
  logic [W-1:0] r_sum;    // sum of completed product terms
  logic [W-1:0] r_mul;    // product of factors so far in the current term
  logic [W-1:0] r_term;   // current term including its latest digit
  logic         r_ovf_f;  // overflow seen somewhere in this expression

  logic [W-1:0] r_result;
  logic         r_done;
  logic         r_err;
  logic         r_ovf;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  ch_class_t    w_cls;
  logic [2*W-1:0] w_prod;   // full-width product, upper half = overflow
  logic [W:0]     w_add;    // sum + term with carry-out

  ascii_class u_class (
    .ch  (bus.in),
    .cls (w_cls)
  );

  always_comb begin
    w_prod = {{W{1'b0}}, r_mul} * {{(2*W-4){1'b0}}, w_cls.digit};
    w_add  = {1'b0, r_sum} + {1'b0, r_term};
  end

  // --------------------------------------------------------------------------
  // FSM and registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= EXP_D;
      r_sum    <= '0;
      r_mul    <= {{(W-1){1'b0}}, 1'b1};
      r_term   <= '0;
      r_ovf_f  <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.in_valid) begin
        // Any '=' terminates the expression and restarts accumulation,
        // whatever state it arrives in.
        if (w_cls.is_eq) begin
          r_done  <= 1'b1;
          r_state <= EXP_D;
          r_sum   <= '0;
          r_mul   <= {{(W-1){1'b0}}, 1'b1};
          r_term  <= '0;
          r_ovf_f <= 1'b0;
          if (r_state == EXP_OP) begin
            r_result <= w_add[W-1:0];
            r_err    <= 1'b0;
            r_ovf    <= r_ovf_f | w_add[W];
          end else begin
            // empty expression, trailing operator, or earlier error
            r_err <= 1'b1;
            r_ovf <= 1'b0;
          end
        end else begin
          case (r_state)
            EXP_D: begin
              if (w_cls.is_digit) begin
                r_term  <= w_prod[W-1:0];
                r_ovf_f <= r_ovf_f | (|w_prod[2*W-1:W]);
                r_state <= EXP_OP;
              end else begin
                r_state <= ERR;
              end
            end
            EXP_OP: begin
              if (w_cls.is_star) begin
                r_mul   <= r_term;
                r_state <= EXP_D;
              end else if (w_cls.is_plus) begin
                r_sum   <= w_add[W-1:0];
                r_ovf_f <= r_ovf_f | w_add[W];
                r_mul   <= {{(W-1){1'b0}}, 1'b1};
                r_state <= EXP_D;
              end else begin
                // a second digit (multi-digit number) or a foreign char
                r_state <= ERR;
              end
            end
            default: r_state <= ERR;
          endcase
        end
      end
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.ovf    = r_ovf;

endmodule : expr_eval
`default_nettype wire
